cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter -- two-requester front end for a single shared 32-bit branch
// comparator.
//
// Each requester issues an RV32I branch compare (funct3 opcode plus two
// operands). Only one compare is in flight at a time:
//   IDLE -> EXEC -> RESP -> (EXEC | IDLE)
// Ties are broken round-robin, or fixed to requester 0 when FIXED_PRIO = 1.
//
// Parameters
//   FIXED_PRIO    0 = round-robin, 1 = requester 0 always wins a tie
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   rN_req_valid / rN_req_ready    request handshake for requester N
//   rN_op, rN_a, rN_b              opcode (funct3) and operands
//   rN_rsp_valid / rN_rsp_ready    response handshake for requester N
//   rsp_result                     1 = branch condition true
//   rsp_err                        opcode of the current result was illegal
//   busy                           block is not idle
//
// comparator_32bit (same file): combinational equal / smaller with a
// signed/unsigned select.

module comparator_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_is_unsigned,
    output logic        o_equal,
    output logic        o_smaller
);
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;

    assign w_sa      = i_a;
    assign w_sb      = i_b;
    assign o_equal   = (i_a == i_b);
    assign o_smaller = i_is_unsigned ? (i_a < i_b) : (w_sa < w_sb);
endmodule

module cmp_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req_valid,
    input  logic        r1_req_valid,
    output logic        r0_req_ready,
    output logic        r1_req_ready,
    input  logic [2:0]  r0_op,
    input  logic [2:0]  r1_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic        r0_rsp_valid,
    output logic        r1_rsp_valid,
    input  logic        r0_rsp_ready,
    input  logic        r1_rsp_ready,
    output logic        rsp_result,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_owner;
    logic        r_last;      // requester granted most recently
    logic        r_result;
    logic        r_err;

    logic        w_equal;
    logic        w_smaller;
    logic        w_cmp_result;
    logic        w_cmp_err;
    logic        w_win;
    logic        w_owner_rsp_ready;
    logic        w_can_accept;
    logic        w_accept;

    // The comparator sees only latched operands, never live request inputs.
    comparator_32bit u_cmp (
        .i_a           (r_a),
        .i_b           (r_b),
        .i_is_unsigned (r_op[1]),
        .o_equal       (w_equal),
        .o_smaller     (w_smaller)
    );

    always_comb begin
        w_cmp_result = 1'b0;
        w_cmp_err    = 1'b0;
        case (r_op)
            3'b000:  w_cmp_result = w_equal;
            3'b001:  w_cmp_result = ~w_equal;
            3'b100:  w_cmp_result = w_smaller;
            3'b101:  w_cmp_result = ~w_smaller;
            3'b110:  w_cmp_result = w_smaller;
            3'b111:  w_cmp_result = ~w_smaller;
            default: w_cmp_err    = 1'b1;
        endcase
    end

    // Tie goes to whoever was not granted last (or always r0 when fixed).
    always_comb begin
        if (r0_req_valid && r1_req_valid) begin
            w_win = FIXED_PRIO ? 1'b0 : ~r_last;
        end else begin
            w_win = r1_req_valid;
        end
    end

    assign w_owner_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;

    // Gated with rst so ready drops the moment reset is applied.
    assign w_can_accept = !rst && ((r_state == S_IDLE) ||
                                   ((r_state == S_RESP) && w_owner_rsp_ready));
    assign w_accept     = w_can_accept && (r0_req_valid || r1_req_valid);

    assign r0_req_ready = w_can_accept && r0_req_valid && !w_win;
    assign r1_req_ready = w_can_accept && r1_req_valid &&  w_win;
    assign r0_rsp_valid = (r_state == S_RESP) && !r_owner;
    assign r1_rsp_valid = (r_state == S_RESP) &&  r_owner;
    assign rsp_result   = r_result;
    assign rsp_err      = r_err;
    assign busy         = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: w_state_nxt = w_accept ? S_EXEC : S_IDLE;
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_owner_rsp_ready) begin
                    w_state_nxt = w_accept ? S_EXEC : S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_result <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_win ? r1_op : r0_op;
                r_a     <= w_win ? r1_a  : r0_a;
                r_b     <= w_win ? r1_b  : r0_b;
                r_owner <= w_win;
                r_last  <= w_win;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_cmp_result;
                r_err    <= w_cmp_err;
            end
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter: a table of single-requester compares with a
// response scoreboard, plus hand-written sequences for arbitration,
// response back-pressure and reset during a compare.

module tb_cmp_arbiter;
    logic        clk;
    logic        rst;
    logic        r0_req_valid, r1_req_valid;
    logic [2:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_rsp_ready, r1_rsp_ready;

    logic r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid;
    logic rsp_result, rsp_err, busy;
    logic f_r0_req_ready, f_r1_req_ready, f_r0_rsp_valid, f_r1_rsp_valid;
    logic f_rsp_result, f_rsp_err, f_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          who;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        res;
        logic        err;
    } vec_t;

    typedef struct {
        int   who;
        logic res;
        logic err;
    } exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];

    cmp_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
        .r0_req_ready(r0_req_ready), .r1_req_ready(r1_req_ready),
        .r0_op(r0_op), .r1_op(r1_op),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    cmp_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
        .r0_req_ready(f_r0_req_ready), .r1_req_ready(f_r1_req_ready),
        .r0_op(r0_op), .r1_op(r1_op),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_rsp_valid(f_r0_rsp_valid), .r1_rsp_valid(f_r1_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
        .rsp_result(f_rsp_result), .rsp_err(f_rsp_err), .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int who, input logic v, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (who == 0) begin
            r0_req_valid = v; r0_op = op; r0_a = a; r0_b = b;
        end else begin
            r1_req_valid = v; r1_op = op; r1_a = a; r1_b = b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_and_compare(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_rsp_valid"}, e.who == 0 ? r0_rsp_valid : r1_rsp_valid, 1);
            check({name, "_other_rsp_valid"}, e.who == 0 ? r1_rsp_valid : r0_rsp_valid, 0);
            check({name, "_result"}, rsp_result, e.res);
            check({name, "_err"}, rsp_err, e.err);
        end
    endtask

    // Called with the DUT idle, #1 after a rising edge.
    task automatic run_single(input int idx);
        vec_t  v;
        exp_t  e;
        string nm;
        v  = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        drive_req(v.who, 1'b1, v.op, v.a, v.b);
        #1;
        check({nm, "_req_ready"}, v.who == 0 ? r0_req_ready : r1_req_ready, 1);
        e.who = v.who; e.res = v.res; e.err = v.err;
        sb_q.push_back(e);
        tick();                                   // accept edge
        drive_req(v.who, 1'b0, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
        check({nm, "_exec_no_rsp"}, v.who == 0 ? r0_rsp_valid : r1_rsp_valid, 0);
        tick();                                   // result loaded
        pop_and_compare(nm);
        if (v.who == 0) r0_rsp_ready = 1'b1; else r1_rsp_ready = 1'b1;
        tick();
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b0;
        check({nm, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int g_rr[$];
        int g_fp[$];
        int exp_rr[4];
        int exp_fp[4];
        exp_t e;

        vecs[0]  = '{0, 3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0}; // BLT  -1 < 1
        vecs[1]  = '{0, 3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0}; // BLTU
        vecs[2]  = '{1, 3'b000, 32'h12345678, 32'h12345678, 1'b1, 1'b0}; // BEQ
        vecs[3]  = '{1, 3'b001, 32'h12345678, 32'h12345678, 1'b0, 1'b0}; // BNE
        vecs[4]  = '{1, 3'b111, 32'h00000000, 32'h00000000, 1'b1, 1'b0}; // BGEU 0,0
        vecs[5]  = '{0, 3'b010, 32'h00000005, 32'h00000009, 1'b0, 1'b1}; // illegal
        vecs[6]  = '{1, 3'b011, 32'h00000009, 32'h00000005, 1'b0, 1'b1}; // illegal
        vecs[7]  = '{0, 3'b101, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0}; // BGE -1 >= 1
        vecs[8]  = '{1, 3'b111, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0}; // BGEU
        vecs[9]  = '{0, 3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0}; // BLT min<max
        vecs[10] = '{1, 3'b110, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0}; // BLTU
        vecs[11] = '{0, 3'b001, 32'h00000001, 32'h00000002, 1'b1, 1'b0}; // BNE differ

        exp_rr = '{0, 1, 0, 1};
        exp_fp = '{0, 0, 0, 0};

        // Reset with both requesters pending: every output low.
        rst = 1'b1;
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;
        drive_req(0, 1'b1, 3'b000, 32'h11, 32'h11);
        drive_req(1, 1'b1, 3'b000, 32'h22, 32'h22);
        tick();
        tick();
        check("rst_r0_req_ready", r0_req_ready, 0);
        check("rst_r1_req_ready", r1_req_ready, 0);
        check("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
        check("rst_result_err", {rsp_result, rsp_err}, 0);
        check("rst_busy", busy, 0);

        // Release: r0 wins the first tie, accepted on the next edge.
        rst = 1'b0;
        #1;
        check("first_tie_r0_ready", r0_req_ready, 1);
        check("first_tie_r1_ready", r1_req_ready, 0);
        for (int c = 0; c < 9; c++) begin
            if (r0_req_valid && r0_req_ready) g_rr.push_back(0);
            if (r1_req_valid && r1_req_ready) g_rr.push_back(1);
            if (r0_req_valid && f_r0_req_ready) g_fp.push_back(0);
            if (r1_req_valid && f_r1_req_ready) g_fp.push_back(1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i), (i < g_rr.size()) ? g_rr[i] : -1, exp_rr[i]);
            check($sformatf("fp_grant%0d", i), (i < g_fp.size()) ? g_fp[i] : -1, exp_fp[i]);
        end
        drive_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (4) tick();
        check("drain_busy", busy, 0);
        check("drain_fp_busy", f_busy, 0);
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b0;

        for (int i = 0; i < 12; i++) run_single(i);

        // Back-pressure: r0 holds its result while r1 waits.
        drive_req(0, 1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000001);
        e.who = 0; e.res = 1'b1; e.err = 1'b0;
        sb_q.push_back(e);
        tick();
        drive_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_req(1, 1'b1, 3'b000, 32'h5, 32'h5);
        r0_rsp_ready = 1'b1;                      // must be ignored in EXEC
        #1;
        check("hold_exec_r1_ready", r1_req_ready, 0);
        tick();
        r0_rsp_ready = 1'b0;
        #1;
        pop_and_compare("hold_first");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_result", i), rsp_result, 1);
            check($sformatf("hold%0d_r0_rsp_valid", i), r0_rsp_valid, 1);
            check($sformatf("hold%0d_r1_req_ready", i), r1_req_ready, 0);
            check($sformatf("hold%0d_r1_rsp_valid", i), r1_rsp_valid, 0);
            tick();
        end
        r0_rsp_ready = 1'b1;
        #1;
        check("release_r1_req_ready", r1_req_ready, 1);
        e.who = 1; e.res = 1'b1; e.err = 1'b0;
        sb_q.push_back(e);
        tick();
        r0_rsp_ready = 1'b0;
        drive_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
        check("release_r0_rsp_dropped", r0_rsp_valid, 0);
        check("release_busy", busy, 1);
        tick();
        pop_and_compare("hold_second");
        r1_rsp_ready = 1'b1;
        tick();
        r1_rsp_ready = 1'b0;

        // Reset mid-EXEC after r0 was granted last.
        run_single(2);                            // r1 granted
        drive_req(0, 1'b1, 3'b000, 32'h7, 32'h7);
        tick();                                   // r0 accepted, now in EXEC
        drive_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_req(1, 1'b1, 3'b000, 32'h7, 32'h7);
        rst = 1'b1;
        #1;
        check("midexec_busy", busy, 0);
        check("midexec_r1_req_ready", r1_req_ready, 0);
        check("midexec_result", rsp_result, 0);
        check("midexec_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
        tick();
        rst = 1'b0;
        drive_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("postrst%0d_rsp_valid", i), {r0_rsp_valid, r1_rsp_valid}, 0);
            check($sformatf("postrst%0d_busy", i), busy, 0);
            tick();
        end
        drive_req(0, 1'b1, 3'b000, 32'h1, 32'h1);
        drive_req(1, 1'b1, 3'b000, 32'h1, 32'h1);
        #1;
        check("postrst_tie_r0_ready", r0_req_ready, 1);
        check("postrst_tie_r1_ready", r1_req_ready, 0);
        tick();
        drive_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
        r0_rsp_ready = 1'b1;
        repeat (3) tick();
        r0_rsp_ready = 1'b0;
        check("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
